// File: rtl/fdas_calbus_pkg.sv
// Shared types and constants for the FDAS calibration bus router.
// Broadcast support is enabled by defining FDAS_CALBUS_BCAST_EN.
package fdas_calbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ERR_DATA    = 32'hDEADBEEF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fdas_calbus_lat_cnt.sv
// Read-latency counter: load LAT on a read strobe, count down, and flag done
// in the cycle the read data is due on the calibration bus.
module fdas_calbus_lat_cnt #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    logic [3:0] cnt;
    logic       busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 4'd0;
            busy <= 1'b0;
        end else if (load) begin
            cnt  <= 4'(LAT);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == 4'd0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign done = busy && (cnt == 4'd0);

endmodule

// File: rtl/fdas_calbus_router.sv
// Routes host (Avalon-MM style) accesses to one of NUM_CH EMIF calibration buses.
// Define FDAS_CALBUS_BCAST_EN to let writes with the broadcast bit hit all channels.
module fdas_calbus_router
    import fdas_calbus_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int ADDR_W = 20,
    parameter  int DATA_W = 32,
    parameter  int RD_LAT = 2,
    localparam int CH_W   = (NUM_CH <= 1) ? 1 : $clog2(NUM_CH),
    localparam int HA_W   = 1 + CH_W + ADDR_W
) (
    input  logic                     calbus_clk,
    input  logic                     calbus_rst_n,
    input  logic [HA_W-1:0]          av_address,
    input  logic                     av_read,
    input  logic                     av_write,
    input  logic [DATA_W-1:0]        av_writedata,
    output logic [DATA_W-1:0]        av_readdata,
    output logic                     av_readdatavalid,
    output logic                     av_waitrequest,
    output logic [1:0]               av_response,
    output logic [NUM_CH-1:0]        calbus_read,
    output logic [NUM_CH-1:0]        calbus_write,
    output logic [NUM_CH*ADDR_W-1:0] calbus_address,
    output logic [NUM_CH*DATA_W-1:0] calbus_wdata,
    input  logic [NUM_CH*DATA_W-1:0] calbus_rdata,
    output logic [7:0]               err_cnt,
    output logic [1:0]               fsm_state
);

    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    state_t state, state_nxt;
    logic   rst_done;
    logic   lat_done;

    logic              bcast;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;
    logic              ch_ok, wr_ok, rd_ok;
    logic              accept_wr, accept_rd;
    logic [NUM_CH-1:0] sel_mask, wr_mask, acc_mask;

    logic [NUM_CH-1:0] wr_stb_q, rd_stb_q;
    logic [ADDR_W-1:0] addr_q  [NUM_CH];
    logic [DATA_W-1:0] wdata_q [NUM_CH];
    logic [CH_W-1:0]   rd_ch_q;
    logic              rd_err_q;
    logic [DATA_W-1:0] rd_data_q, rdata_sel;
    logic [1:0]        resp_q;
    logic [7:0]        err_q;

    assign bcast = av_address[HA_W-1];
    assign ch    = av_address[ADDR_W +: CH_W];
    assign addr  = av_address[ADDR_W-1:0];

    // Requests are only taken once the post-reset settle cycle has passed.
    assign accept_wr = (state == ST_IDLE) && rst_done && av_write;
    assign accept_rd = (state == ST_IDLE) && rst_done && av_read && !av_write;

    always_comb begin
        sel_mask = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_mask[c] = (int'(ch) == c);
        end
        ch_ok = (int'(ch) < NUM_CH);
        rd_ok = !bcast && ch_ok;
`ifdef FDAS_CALBUS_BCAST_EN
        wr_ok   = bcast || ch_ok;
        wr_mask = bcast ? {NUM_CH{1'b1}} : sel_mask;
`else
        wr_ok   = !bcast && ch_ok;
        wr_mask = sel_mask;
`endif
        acc_mask = '0;
        if (accept_wr && wr_ok) begin
            acc_mask = wr_mask;
        end else if (accept_rd && rd_ok) begin
            acc_mask = sel_mask;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_wr) begin
                    state_nxt = ST_WR;
                end else if (accept_rd) begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_WR:      state_nxt = ST_IDLE;
            ST_RD_WAIT: if (lat_done) state_nxt = ST_RESP;
            ST_RESP:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge calbus_clk or negedge calbus_rst_n) begin
        if (!calbus_rst_n) begin
            state    <= ST_IDLE;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
        end
    end

    fdas_calbus_lat_cnt #(
        .LAT (RD_LAT)
    ) u_lat_cnt (
        .clk   (calbus_clk),
        .rst_n (calbus_rst_n),
        .load  (accept_rd),
        .done  (lat_done)
    );

    always_comb begin
        rdata_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(rd_ch_q) == c) begin
                rdata_sel = calbus_rdata[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge calbus_clk or negedge calbus_rst_n) begin
        if (!calbus_rst_n) begin
            wr_stb_q  <= '0;
            rd_stb_q  <= '0;
            rd_ch_q   <= '0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
            resp_q    <= RESP_OKAY;
            err_q     <= 8'd0;
            for (int c = 0; c < NUM_CH; c++) begin
                addr_q[c]  <= '0;
                wdata_q[c] <= '0;
            end
        end else begin
            wr_stb_q <= (accept_wr && wr_ok) ? wr_mask : '0;
            rd_stb_q <= (accept_rd && rd_ok) ? sel_mask : '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc_mask[c]) begin
                    addr_q[c] <= addr;
                    if (accept_wr) begin
                        wdata_q[c] <= av_writedata;
                    end
                end
            end
            if (accept_rd) begin
                rd_ch_q  <= ch;
                rd_err_q <= !rd_ok;
            end
            // Capture in the cycle the calbus data is due, i.e. RD_LAT after the strobe.
            if ((state == ST_RD_WAIT) && lat_done) begin
                rd_data_q <= rd_err_q ? ERR_WORD : rdata_sel;
                resp_q    <= rd_err_q ? RESP_SLVERR : RESP_OKAY;
            end
            if ((accept_wr && !wr_ok) || (accept_rd && !rd_ok)) begin
                err_q <= sat_inc8(err_q);
            end
        end
    end

    always_comb begin
        calbus_address = '0;
        calbus_wdata   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            calbus_address[c*ADDR_W +: ADDR_W] = addr_q[c];
            calbus_wdata[c*DATA_W +: DATA_W]   = wdata_q[c];
        end
    end

    assign av_waitrequest   = !((state == ST_IDLE) && rst_done);
    assign av_readdatavalid = (state == ST_RESP);
    assign av_readdata      = (state == ST_RESP) ? rd_data_q : '0;
    assign av_response      = (state == ST_RESP) ? resp_q : RESP_OKAY;
    assign calbus_write     = wr_stb_q;
    assign calbus_read      = rd_stb_q;
    assign err_cnt          = err_q;
    assign fsm_state        = state;

endmodule

// File: tb/tb_fdas_calbus_router.sv
// Directed bench for fdas_calbus_router (NUM_CH=3, RD_LAT=2); broadcast
// expectations follow FDAS_CALBUS_BCAST_EN.
module tb_fdas_calbus_router;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int HA_W   = 1 + 2 + ADDR_W;

    logic                     clk;
    logic                     rst_n;
    logic [HA_W-1:0]          av_address;
    logic                     av_read;
    logic                     av_write;
    logic [DATA_W-1:0]        av_writedata;
    logic [DATA_W-1:0]        av_readdata;
    logic                     av_readdatavalid;
    logic                     av_waitrequest;
    logic [1:0]               av_response;
    logic [NUM_CH-1:0]        calbus_read;
    logic [NUM_CH-1:0]        calbus_write;
    logic [NUM_CH*ADDR_W-1:0] calbus_address;
    logic [NUM_CH*DATA_W-1:0] calbus_wdata;
    logic [NUM_CH*DATA_W-1:0] calbus_rdata;
    logic [7:0]               err_cnt;
    logic [1:0]               fsm_state;

    fdas_calbus_router #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .calbus_clk       (clk),
        .calbus_rst_n     (rst_n),
        .av_address       (av_address),
        .av_read          (av_read),
        .av_write         (av_write),
        .av_writedata     (av_writedata),
        .av_readdata      (av_readdata),
        .av_readdatavalid (av_readdatavalid),
        .av_waitrequest   (av_waitrequest),
        .av_response      (av_response),
        .calbus_read      (calbus_read),
        .calbus_write     (calbus_write),
        .calbus_address   (calbus_address),
        .calbus_wdata     (calbus_wdata),
        .calbus_rdata     (calbus_rdata),
        .err_cnt          (err_cnt),
        .fsm_state        (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic        bc;
        logic [1:0]  ch;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [2:0]  exp_wstb;
        logic [2:0]  exp_rstb;
        logic        exp_rv;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_err_inc;
    } vec_t;

    localparam logic [95:0] GOOD_RDATA = {32'h33334444, 32'h11112222, 32'hCAFEF00D};

    vec_t        vecs[9];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [19:0] exp_addr[3];
    logic [31:0] exp_wd[3];
    int          exp_err = 0;

    function automatic vec_t mk(input logic wr, rd, bc, input logic [1:0] ch,
                                input logic [19:0] addr, input logic [31:0] wdata,
                                input logic [2:0] ew, er, input logic erv,
                                input logic [31:0] ed, input logic [1:0] eresp,
                                input int einc);
        vec_t v;
        v.wr = wr; v.rd = rd; v.bc = bc; v.ch = ch; v.addr = addr; v.wdata = wdata;
        v.exp_wstb = ew; v.exp_rstb = er; v.exp_rv = erv; v.exp_rdata = ed;
        v.exp_resp = eresp; v.exp_err_inc = einc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (av_waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {127'd0, av_waitrequest}, 128'd0);
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        logic [17:0] w_tr, r_tr, w_exp, r_exp;
        logic [5:0]  rv_tr, rv_exp;
        logic [31:0] rd_at4;
        logic [1:0]  resp_at4;
        logic [59:0] addr_at1, addr_exp;
        logic [95:0] wd_at1, wd_exp;
        wait_idle();
        av_address   = {v.bc, v.ch, v.addr};
        av_read      = v.rd;
        av_write     = v.wr;
        av_writedata = v.wdata;
        calbus_rdata = ~GOOD_RDATA;
        @(posedge clk);
        #1;
        av_read  = 1'b0;
        av_write = 1'b0;
        w_tr = '0; r_tr = '0; rv_tr = '0; rd_at4 = '0; resp_at4 = '0;
        addr_at1 = '0; wd_at1 = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            w_tr[(k-1)*3 +: 3] = calbus_write;
            r_tr[(k-1)*3 +: 3] = calbus_read;
            rv_tr[k-1]         = av_readdatavalid;
            if (k == 1) begin
                addr_at1 = calbus_address;
                wd_at1   = calbus_wdata;
            end
            if (k == 4) begin
                rd_at4   = av_readdata;
                resp_at4 = av_response;
            end
            // Only the cycle RD_LAT after the strobe carries valid calbus data.
            calbus_rdata = (k == 1 + RD_LAT) ? GOOD_RDATA : ~GOOD_RDATA;
        end
        for (int c = 0; c < 3; c++) begin
            if (v.exp_wstb[c] || v.exp_rstb[c]) exp_addr[c] = v.addr;
            if (v.exp_wstb[c]) exp_wd[c] = v.wdata;
        end
        exp_err = (exp_err + v.exp_err_inc > 255) ? 255 : exp_err + v.exp_err_inc;
        w_exp    = {15'd0, v.exp_wstb};
        r_exp    = {15'd0, v.exp_rstb};
        rv_exp   = v.exp_rv ? 6'b001000 : 6'b000000;
        addr_exp = {exp_addr[2], exp_addr[1], exp_addr[0]};
        wd_exp   = {exp_wd[2], exp_wd[1], exp_wd[0]};
        chk({tag, "_wstb_trace"}, w_tr, w_exp);
        chk({tag, "_rstb_trace"}, r_tr, r_exp);
        chk({tag, "_rvalid_trace"}, rv_tr, rv_exp);
        chk({tag, "_address"}, addr_at1, addr_exp);
        chk({tag, "_wdata"}, wd_at1, wd_exp);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        if (v.exp_rv) begin
            chk({tag, "_rdata"}, rd_at4, v.exp_rdata);
            chk({tag, "_resp"}, resp_at4, v.exp_resp);
        end
    endtask

    initial begin
        logic saw_rv;
        rst_n        = 1'b0;
        av_address   = '0;
        av_read      = 1'b0;
        av_write     = 1'b0;
        av_writedata = '0;
        calbus_rdata = GOOD_RDATA;
        for (int c = 0; c < 3; c++) begin
            exp_addr[c] = '0;
            exp_wd[c]   = '0;
        end

        //      wr rd bc ch addr        wdata          wstb    rstb    rv exp_rdata      resp   inc
        vecs[0] = mk(1, 0, 0, 1, 20'h00010, 32'h12345678, 3'b010, 3'b000, 0, 32'h0,        2'b00, 0);
        vecs[1] = mk(0, 1, 0, 0, 20'h00004, 32'h0,        3'b000, 3'b001, 1, 32'hCAFEF00D, 2'b00, 0);
        vecs[2] = mk(0, 1, 0, 3, 20'h00008, 32'h0,        3'b000, 3'b000, 1, 32'hDEADBEEF, 2'b10, 1);
        vecs[3] = mk(1, 0, 0, 3, 20'h0000C, 32'h55555555, 3'b000, 3'b000, 0, 32'h0,        2'b00, 1);
        vecs[4] = mk(1, 1, 0, 2, 20'h00020, 32'hAAAA5555, 3'b100, 3'b000, 0, 32'h0,        2'b00, 0);
        vecs[5] = mk(0, 1, 0, 2, 20'h00030, 32'h0,        3'b000, 3'b100, 1, 32'h33334444, 2'b00, 0);
`ifdef FDAS_CALBUS_BCAST_EN
        vecs[6] = mk(1, 0, 1, 0, 20'h00040, 32'hA5A5A5A5, 3'b111, 3'b000, 0, 32'h0,        2'b00, 0);
`else
        vecs[6] = mk(1, 0, 1, 0, 20'h00040, 32'hA5A5A5A5, 3'b000, 3'b000, 0, 32'h0,        2'b00, 1);
`endif
        vecs[7] = mk(0, 1, 1, 1, 20'h00044, 32'h0,        3'b000, 3'b000, 1, 32'hDEADBEEF, 2'b10, 1);
        vecs[8] = mk(0, 1, 0, 1, 20'h000FF, 32'h0,        3'b000, 3'b010, 1, 32'h11112222, 2'b00, 0);

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        chk("rst_waitrequest", av_waitrequest, 1'b1);
        chk("rst_outputs", {av_readdatavalid, av_readdata, av_response, calbus_read, calbus_write},
            128'd0);
        chk("rst_address_wdata", {calbus_address, calbus_wdata}, 128'd0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        chk("rst_fsm_state", fsm_state, 2'd0);

        rst_n = 1'b1;
        #1;
        chk("release_waitrequest_before_edge", av_waitrequest, 1'b1);
        @(posedge clk);
        #1;
        chk("release_waitrequest_after_edge", av_waitrequest, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Saturation: enough invalid-channel reads to pass 255.
        for (int i = 0; i < 300; i++) begin
            do_txn(vecs[2], "sat");
        end
        chk("err_cnt_saturated", err_cnt, 8'd255);

        // Reset in the middle of a read must abort it with no readdatavalid.
        wait_idle();
        av_address = {1'b0, 2'd0, 20'h00004};
        av_read    = 1'b1;
        @(posedge clk);
        #1;
        av_read = 1'b0;
        @(negedge clk);
        chk("midrd_in_rd_wait", fsm_state, 2'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrd_rst_fsm_state", fsm_state, 2'd0);
        chk("midrd_rst_err_cnt", err_cnt, 8'd0);
        chk("midrd_rst_waitrequest", av_waitrequest, 1'b1);
        saw_rv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            saw_rv = saw_rv | av_readdatavalid;
            if (k == 1) rst_n = 1'b1;
        end
        chk("midrd_no_readdatavalid", saw_rv, 1'b0);
        chk("midrd_err_cnt_after", err_cnt, 8'd0);
        chk("midrd_fsm_idle_after", fsm_state, 2'd0);
        for (int c = 0; c < 3; c++) begin
            exp_addr[c] = '0;
            exp_wd[c]   = '0;
        end
        exp_err = 0;
        do_txn(vecs[1], "post_reset_read");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
